data_mem: RTL and testbench

Parametrised, byte-addressed data memory for the RISC-V core's load/store path; successor to the original word-indexed data memory. Adds a valid/ready request handshake, configurable access latency, true byte/halfword lane handling (sub-word stores merge into the addressed word), misalignment/range/funct3 error reporting, and a one-cycle response pulse. Sits between the core's memory stage and the data array; the core stalls until `rsp_valid`.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_align.sv | 63 ++++++
 rtl/data_mem.sv | 139 +++++++++++++
 tb/tb_data_mem.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-addressed data memory.
// funct3 codes, FSM states and the latency ceiling.
package dmem_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// Lane steering for data_mem: byte enables, shifted store data,
// misalignment detection and extended load results.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rword >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_lane[1] ? i_rword[31:16]
                             : i_rword[15:0];

  // Load and store codes overlap (0/1/2), so both
  // views are produced and the top picks by we.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = '0;
    o_misalign = 1'b0;
    o_rdata    = '0;
    unique case (i_funct3)
      LB: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      LH: begin
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_lane[0];
        o_rdata    = {{16{w_half[15]}}, w_half};
      end
      LW: begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = |i_lane;
        o_rdata    = i_rword;
      end
      LBU: begin
        o_rdata = {24'd0, w_byte};
      end
      LHU: begin
        o_misalign = i_lane[0];
        o_rdata    = {16'd0, w_half};
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory with valid/ready requests,
// programmable wait latency and a one-cycle response pulse.
module data_mem
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    LATENCY   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [31:0] r_mem [WORDS];

  state_t      r_state, w_state_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept, w_exec;
  logic        w_x_we;
  logic [2:0]  w_x_f3;
  logic [31:0] w_x_addr, w_x_wdata;
  logic [ADDR_W-3:0] w_idx;
  logic [31:0] w_rword, w_wlane, w_load;
  logic [3:0]  w_be;
  logic        w_misalign, w_f3_bad;
  logic        w_oor, w_err;

  assign req_ready = rst_n && (r_state != S_WAIT);
  assign w_accept  = req_valid && req_ready;

  // Zero latency executes straight off the request bus.
  assign w_x_we    = (r_state == S_WAIT) ? r_we : req_we;
  assign w_x_f3    = (r_state == S_WAIT) ? r_f3 : req_funct3;
  assign w_x_addr  = (r_state == S_WAIT) ? r_addr : req_addr;
  assign w_x_wdata = (r_state == S_WAIT) ? r_wdata : req_wdata;

  assign w_exec = (LATENCY == 0) ? w_accept
                : (rst_n && r_state == S_WAIT && r_cnt == 4'd0);

  assign w_idx   = w_x_addr[ADDR_W-1:2];
  assign w_rword = r_mem[w_idx];

  dmem_align u_align (
    .i_funct3   (w_x_f3),
    .i_lane     (w_x_addr[1:0]),
    .i_wdata    (w_x_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wlane),
    .o_misalign (w_misalign),
    .o_rdata    (w_load)
  );

  assign w_oor    = |(w_x_addr >> ADDR_W);
  assign w_f3_bad = w_x_we ? (w_x_f3 > SW)
                  : (w_x_f3 == 3'd3 || w_x_f3 >= 3'd6);
  assign w_err    = w_oor || w_misalign || w_f3_bad;

  always_ff @(posedge clk) begin
    if (w_exec && w_x_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_n = S_RESP;
        else w_cnt_n = r_cnt - 4'd1;
      end
      default: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_state_n = S_RESP;
          end else begin
            w_state_n = S_WAIT;
            w_cnt_n   = LAT_M1;
          end
        end else begin
          w_state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_exec) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_x_we) ? 32'd0 : w_load;
      end
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: a zero-latency and a
// three-cycle instance driven side by side.
module tb_data_mem;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0 = 0, we0 = 0, rdy0, rv0, e0;
  logic [2:0]  f0 = 0;
  logic [31:0] a0 = 0, d0 = 0, rd0;
  logic        v3 = 0, we3 = 0, rdy3, rv3, e3;
  logic [2:0]  f3 = 0;
  logic [31:0] a3 = 0, d3 = 0, rd3;

  data_mem #(.ADDR_W(10), .LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_funct3(f0), .req_addr(a0), .req_wdata(d0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(e0)
  );

  data_mem #(.ADDR_W(10), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_funct3(f3), .req_addr(a3), .req_wdata(d3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(e3)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t q0[$], q3[$];
  exp_t x0, x3;
  int total = 0, bad = 0;
  int cyc = 0, run = 0, maxrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rv0) begin
      run++;
      if (run > maxrun) maxrun = run;
      if (q0.size() == 0) chk("u0_unexp", 1, 0);
      else begin
        x0 = q0.pop_front();
        chk("u0_rdata", rd0, x0.d);
        chk("u0_err", e0, x0.e);
        chk("u0_lat", cyc, x0.due);
      end
    end else run = 0;
    if (rv3) begin
      if (q3.size() == 0) chk("u3_unexp", 1, 0);
      else begin
        x3 = q3.pop_front();
        chk("u3_rdata", rd3, x3.d);
        chk("u3_err", e3, x3.e);
        chk("u3_lat", cyc, x3.due);
      end
    end
  end

  task automatic req(input int s, input logic we,
                     input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee,
                     input bit push);
    @(negedge clk);
    if (s == 0) begin
      v0 = 1; we0 = we; f0 = f; a0 = a; d0 = d;
    end else begin
      v3 = 1; we3 = we; f3 = f; a3 = a; d3 = d;
    end
    @(posedge clk);
    #1;
    if (push) begin
      if (s == 0) q0.push_back('{ed, ee, cyc});
      else q3.push_back('{ed, ee, cyc + 3});
    end
  endtask

  task automatic drop();
    @(negedge clk);
    v0 = 0;
    v3 = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk(tag, q0.size() + q3.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_e0", e0, 0);
    chk("rst_rdy3", rdy3, 0);
    #11 rst_n = 1;
    #1;
    chk("rel_rdy0", rdy0, 1);
    chk("rel_rdy3", rdy3, 1);

    req(0, 1, SW, 32'h10, 32'hDEADBEEF, 0, 0, 1);
    req(0, 0, LW, 32'h10, 0, 32'hDEADBEEF, 0, 1);
    drop();
    drain("drain_basic");

    req(0, 1, SW, 32'h10, 32'h11223344, 0, 0, 1);
    req(0, 1, SB, 32'h13, 32'h00000080, 0, 0, 1);
    req(0, 0, LB, 32'h13, 0, 32'hFFFFFF80, 0, 1);
    req(0, 0, LBU, 32'h13, 0, 32'h00000080, 0, 1);
    req(0, 0, LW, 32'h10, 0, 32'h80223344, 0, 1);
    req(0, 0, LH, 32'h12, 0, 32'hFFFF8022, 0, 1);
    req(0, 0, LHU, 32'h12, 0, 32'h00008022, 0, 1);
    req(0, 0, LB, 32'h10, 0, 32'h00000044, 0, 1);
    drop();
    drain("drain_sub");

    req(0, 1, SW, 32'h0, 32'h0, 0, 0, 1);
    req(0, 0, LW, 32'h11, 0, 0, 1, 1);
    req(0, 1, SH, 32'h01, 32'hBEEF, 0, 1, 1);
    req(0, 0, LW, 32'h400, 0, 0, 1, 1);
    req(0, 0, 3'd3, 32'h10, 0, 0, 1, 1);
    req(0, 1, 3'd3, 32'h10, 32'hFFFFFFFF, 0, 1, 1);
    req(0, 1, SW, 32'h12, 32'hFFFFFFFF, 0, 1, 1);
    req(0, 0, LW, 32'h0, 0, 0, 0, 1);
    req(0, 0, LW, 32'h10, 0, 32'h80223344, 0, 1);
    drop();
    drain("drain_err");

    maxrun = 0;
    for (int i = 0; i < 4; i++) begin
      req(0, 1, SW, 32'h100 + 4*i, 32'hA5000000 + i, 0, 0, 1);
      req(0, 0, LW, 32'h100 + 4*i, 0, 32'hA5000000 + i, 0, 1);
    end
    drop();
    drain("drain_b2b");
    chk("b2b_run", maxrun, 8);

    req(3, 1, SW, 32'h20, 32'h0, 0, 0, 1);
    drop();
    drain("drain_l3a");
    req(3, 0, LW, 32'h20, 0, 0, 0, 1);
    v3 = 1; we3 = 1; f3 = SW; a3 = 32'h20; d3 = 32'h77;
    chk("wait_rdy_1", rdy3, 0);
    @(posedge clk); #1;
    chk("wait_rdy_2", rdy3, 0);
    @(posedge clk); #1;
    chk("wait_rdy_3", rdy3, 0);
    @(posedge clk); #1;
    v3 = 0;
    chk("resp_rdy", rdy3, 1);
    drain("drain_l3b");
    req(3, 0, LW, 32'h20, 0, 0, 0, 1);
    drop();
    drain("drain_l3c");

    req(3, 1, SW, 32'h24, 32'h12345678, 0, 0, 1);
    drop();
    drain("drain_l3d");
    req(3, 0, LW, 32'h24, 0, 32'h12345678, 0, 1);
    drop();
    drain("drain_l3e");

    req(3, 1, SW, 32'h20, 32'h5, 0, 0, 0);
    v3 = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rdy", rdy3, 0);
    chk("mid_rv", rv3, 0);
    chk("mid_rd", rd3, 0);
    chk("mid_err", e3, 0);
    repeat (5) @(negedge clk);
    rst_n = 1;
    req(3, 0, LW, 32'h20, 0, 0, 0, 1);
    drop();
    drain("drain_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
